// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM.
// Each access takes one ACCESS cycle and one RESP cycle, and the RESP cycle re-arbitrates.
module dmem_arbiter #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned IW = AW - 2;
  localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          cmd_we_q;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_wdata_q;
  logic          owner_q;     // current owner; doubles as last_owner for round-robin
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          arb;
  logic          win;
  logic          bad;
  logic          in_access;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      owner_q     <= 1'b1;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (arb) begin
        cmd_we_q    <= win ? we1 : we0;
        cmd_addr_q  <= win ? addr1 : addr0;
        cmd_wdata_q <= win ? wdata1 : wdata0;
        owner_q     <= win;
      end
    end
  end

  // Next state and arbitration
  always_comb begin
    state_d = state_q;
    arb     = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        arb = req0 | req1;
        if (req0 && req1) win = FIXED_PRIO ? 1'b0 : ~owner_q;
        else              win = req1;
        state_d = arb ? ACCESS : IDLE;
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Output decode and next values of the response registers
  always_comb begin
    in_access = (state_q == ACCESS);
    bad       = (cmd_addr_q[1:0] != 2'b00) || (cmd_addr_q[AW-1:2] >= DEPTH_IDX);
    ram_we    = in_access & cmd_we_q & ~bad & ~reset;
    gnt_d     = '0;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    if (arb) gnt_d = win ? 2'b10 : 2'b01;
    if (in_access) begin
      rdata_d = (bad || cmd_we_q) ? '0 : ram_dout;
      err_d   = bad;
      done_d  = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign ram_addr = cmd_addr_q;
  assign ram_din  = cmd_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance with a RAM model and a scoreboard,
// plus a fixed-priority instance fed by an address-derived read pattern.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err, ram_we;
  logic [31:0] rdata, ram_addr, ram_din, ram_dout;

  logic        fp_req0, fp_req1;
  logic        fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err, fp_ram_we;
  logic [31:0] fp_rdata, fp_ram_addr, fp_ram_din, fp_ram_dout;

  logic [31:0] mem [512];
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(512), .AW(32), .DW(32), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

  dmem_arbiter #(.DEPTH(512), .AW(32), .DW(32), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset), .req0(fp_req0), .req1(fp_req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1), .rdata(fp_rdata),
    .err(fp_err), .ram_we(fp_ram_we), .ram_addr(fp_ram_addr), .ram_din(fp_ram_din),
    .ram_dout(fp_ram_dout));

  // RAM model: combinational read, write on posedge
  assign ram_dout    = mem[ram_addr[10:2]];
  assign fp_ram_dout = {fp_ram_addr[15:0], 16'hF00D};
  always @(posedge clk) if (ram_we) mem[ram_addr[10:2]] <= ram_din;

  // Scoreboard: every done pulse pops the oldest expectation
  always @(negedge clk) begin
    if (done0 || done1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_done: done=%b with empty scoreboard", {done1, done0});
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({done1, done0} !== e.done || rdata !== e.rdata || err !== e.err)
          $display("FAIL sb_response: got done=%b rdata=%h err=%b, want done=%b rdata=%h err=%b",
                   {done1, done0}, rdata, err, e.done, e.rdata, e.err);
        else n_pass++;
      end
    end
  end

  // Issue one access from an idle arbiter; report grant, write strobe and done as observed
  task automatic do_access(input bit port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                           output logic g_own, output logic g_oth, output logic w, output logic d);
    exp_t e;
    @(negedge clk);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    e.done = port ? 2'b10 : 2'b01; e.rdata = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    g_own = port ? gnt1 : gnt0;
    g_oth = port ? gnt0 : gnt1;
    w     = ram_we;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    d = port ? done1 : done0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, done0, done1, err, ram_we} !== 6'b0 || rdata !== 32'h0 ||
        ram_addr !== 32'h0 || ram_din !== 32'h0)
      $display("FAIL reset_outputs: flags=%b rdata=%h ram_addr=%h ram_din=%h, want all 0",
               {gnt0, gnt1, done0, done1, err, ram_we}, rdata, ram_addr, ram_din);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic g, go, w, d;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, g, go, w, d);
    n_checks++;
    if (g !== 1'b1 || go !== 1'b0 || w !== 1'b1 || d !== 1'b1)
      $display("FAIL wr_handshake: gnt=%b other=%b ram_we=%b done=%b, want 1 0 1 1", g, go, w, d);
    else n_pass++;
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF) $display("FAIL wr_mem4: got %h, want deadbeef", mem[4]);
    else n_pass++;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, g, go, w, d);
    n_checks++;
    if (g !== 1'b1 || go !== 1'b0 || w !== 1'b0 || d !== 1'b1)
      $display("FAIL rd_handshake: gnt=%b other=%b ram_we=%b done=%b, want 1 0 0 1", g, go, w, d);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    exp_t e;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      e.done  = (i % 2 == 0) ? 2'b01 : 2'b10;
      e.rdata = (i % 2 == 0) ? 32'hDEADBEEF : 32'hCAFE0010;
      e.err   = 1'b0;
      sb_q.push_back(e);
    end
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h40;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt0 !== (k == 1 || k == 5) || gnt1 !== (k == 3 || k == 7) ||
          done0 !== (k == 2 || k == 6) || done1 !== (k == 4 || k == 8))
        $display("FAIL rr_cycle%0d: gnt=%b%b done=%b%b", k, gnt1, gnt0, done1, done0);
      else n_pass++;
      if (k == 7) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task automatic test_fixed_prio();
    @(negedge clk);
    fp_req0 = 1'b1; fp_req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h30; addr1 = 32'h44;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (fp_gnt0 !== (k % 2 == 1) || fp_gnt1 !== 1'b0 || fp_done0 !== (k % 2 == 0) ||
          fp_done1 !== 1'b0)
        $display("FAIL fp_cycle%0d: gnt=%b%b done=%b%b", k, fp_gnt1, fp_gnt0, fp_done1, fp_done0);
      else n_pass++;
      if (k % 2 == 0) begin
        n_checks++;
        if (fp_rdata !== 32'h0030F00D || fp_err !== 1'b0)
          $display("FAIL fp_rdata%0d: got %h err=%b, want 0030f00d err=0", k, fp_rdata, fp_err);
        else n_pass++;
      end
      if (k == 7) begin fp_req0 = 1'b0; fp_req1 = 1'b0; end
    end
  endtask

  task automatic test_unaligned();
    logic g, go, w, d;
    do_access(1'b0, 1'b1, 32'h13, 32'h1234, 32'h0, 1'b1, g, go, w, d);
    n_checks++;
    if (g !== 1'b1 || w !== 1'b0 || d !== 1'b1)
      $display("FAIL unaligned_wr: gnt=%b ram_we=%b done=%b, want 1 0 1", g, w, d);
    else n_pass++;
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF) $display("FAIL unaligned_mem4: got %h, want deadbeef", mem[4]);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic g, go, w, d;
    do_access(1'b1, 1'b0, 32'h800, 32'h0, 32'h0, 1'b1, g, go, w, d);
    n_checks++;
    if (g !== 1'b1 || go !== 1'b0 || w !== 1'b0 || d !== 1'b1)
      $display("FAIL oor_rd: gnt=%b other=%b ram_we=%b done=%b, want 1 0 0 1", g, go, w, d);
    else n_pass++;
    do_access(1'b0, 1'b1, 32'h800, 32'h77, 32'h0, 1'b1, g, go, w, d);
    n_checks++;
    if (w !== 1'b0 || mem[0] !== 32'hCAFE0000)
      $display("FAIL oor_wr: ram_we=%b mem0=%h, want 0 cafe0000", w, mem[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    logic g, go, w, d;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h55;
    @(negedge clk);
    n_checks++;
    if (gnt1 !== 1'b1) $display("FAIL rst_gnt1: got %b, want 1", gnt1);
    else n_pass++;
    reset = 1'b1; req1 = 1'b0;
    #1;
    n_checks++;
    if (ram_we !== 1'b0) $display("FAIL rst_ram_we_gated: got %b, want 0", ram_we);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, done0, done1, err, ram_we} !== 6'b0 || rdata !== 32'h0 ||
        ram_addr !== 32'h0 || ram_din !== 32'h0)
      $display("FAIL rst_mid_outputs: flags=%b rdata=%h ram_addr=%h ram_din=%h, want all 0",
               {gnt0, gnt1, done0, done1, err, ram_we}, rdata, ram_addr, ram_din);
    else n_pass++;
    n_checks++;
    if (mem[8] !== 32'hCAFE0008) $display("FAIL rst_mem8: got %h, want cafe0008", mem[8]);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done1 !== 1'b0 || gnt1 !== 1'b0)
      $display("FAIL rst_no_done: done1=%b gnt1=%b, want 0 0", done1, gnt1);
    else n_pass++;
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFE0008, 1'b0, g, go, w, d);
    n_checks++;
    if (g !== 1'b1 || d !== 1'b1)
      $display("FAIL rst_rerequest: gnt1=%b done1=%b, want 1 1", g, d);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {16'hCAFE, 16'(i)};
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    fp_req0 = 1'b0; fp_req1 = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_unaligned();
    test_out_of_range();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d responses never arrived", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
